// File: rtl/shared_adder_arb.sv
// shared_adder_arb: arbitrates one shared combinational adder among NUM_REQ requesters.
// Define SHARED_ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority (default: round robin).
module shared_adder_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              any_v;
  logic              take;
  logic [ID_W-1:0]   gnt;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [WIDTH-1:0]  add_a_q, add_b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic [ID_W-1:0]   id_q, rsp_id_q;

  assign any_v = |req_valid;
  assign take  = (state_q == IDLE) && any_v;

`ifdef SHARED_ADDER_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_valid[i]) gnt = ID_W'(i);
  end
`else
  logic [ID_W-1:0] last_q;

  // Search circularly starting just after the previous winner.
  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        gnt   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_q <= ID_W'(NUM_REQ-1);
    else if (take) last_q <= gnt;
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_v) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = take && !rst && (gnt == ID_W'(i));
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q  <= '0;
      add_b_q  <= '0;
      id_q     <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      if (take) begin
        add_a_q <= sel_a;
        add_b_q <= sel_b;
        id_q    <= gnt;
      end
      if (state_q == EXEC) begin
        sum_q    <= add_sum;
        carry_q  <= add_carry;
        rsp_id_q <= id_q;
      end
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/shared_adder_arb.md
Name: shared_adder_arb

Overview:
- Arbitrates one shared 32-bit combinational adder (`a`, `b` in; `sum`, `carry_out` out) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block registers the winning operands, drives the adder, and captures sum/carry.
- It returns the result, tagged with the requester ID, on a single valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width; must match the shared adder
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a
- add_a  output  WIDTH  to shared adder input a
- add_b  output  WIDTH  to shared adder input b
- add_sum  input  WIDTH  from shared adder sum
- add_carry  input  1  from shared adder carry_out
- rsp_valid  output  1  result valid
- rsp_ready  input  1  downstream accepts result
- rsp_id  output  ID_W  index of requester that owns the result
- rsp_sum  output  WIDTH  captured sum
- rsp_carry  output  1  captured carry
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE; req_ready=0; add_a=0; add_b=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so the first grant after reset searches from requester 0.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid, select g = first valid index searching circularly from last_grant+1.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - On the clock edge: latch req_a[g] into add_a, req_b[g] into add_b, g into the ID register; set last_grant=g; go to EXEC.
  - If no req_valid: stay in IDLE, req_ready=0.
- EXEC (exactly 1 cycle):
  - add_a/add_b are stable registers feeding the adder.
  - On the edge: rsp_sum<=add_sum, rsp_carry<=add_carry, rsp_id<=ID register; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum/rsp_carry/rsp_id held stable until rsp_ready=1.
  - On an edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
  - req_ready=0 throughout.
- Latency and throughput:
  - Request accept edge to rsp_valid high is 2 clocks.
  - Minimum issue interval is 3 clocks per operation (no overlap).
- Arithmetic:
  - Unsigned WIDTH-bit add; rsp_carry is the bit-WIDTH carry from the adder.
  - Wrap-around is not altered: 0xFFFFFFFF+1 gives sum 0, carry 1.
- Requester rules:
  - A requester holds req_valid and operands stable until it sees req_ready.
  - Operand changes while not granted are ignored.
  - req_valid dropped before grant: no transaction and no error.
- Simultaneous requests: only one grant per IDLE cycle; fairness is strict round robin.
  - Example: all four valid continuously gives grant order 0,1,2,3,0,...
- Back-pressure: rsp_ready low holds RESP indefinitely; no new request is accepted until the response is consumed.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - The in-flight result is discarded; no response is emitted.
  - The round-robin pointer is reset.
- rsp_ready high outside RESP has no effect.

Optional Feature:
- Macro: SHARED_ADDER_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins; last_grant is not used.
- Undefined (default): round robin as described above.
- All other timing is identical in both builds.

Test Plan:
- Single op: req_valid[1]=1, a=25, b=49 -> req_ready[1] pulses 1 cycle; rsp_valid 2 clocks later with rsp_sum=74, rsp_carry=0, rsp_id=1.
- Wrap/carry: requester 0, a=0xFFFFFFFF, b=1 -> rsp_sum=0, rsp_carry=1. Then a=7000, b=15000 -> rsp_sum=22000, rsp_carry=0.
- Contention:
  - Stimulus: all four valid with distinct operands (650+1000, 150+300, 6758+2112, 5678+1342), rsp_ready=1.
  - Required: responses in ID order 0,1,2,3 with sums 1650, 450, 8870, 7020. Issue interval 3 clocks; never two req_ready bits high.
- Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_sum and rsp_id held constant; req_ready stays 0 despite other valid requests; completion occurs 1 edge after rsp_ready=1.
- Reset mid-op: assert rst during EXEC -> rsp_valid=0, busy=0 and add_a=add_b=0 immediately. After release, the first grant goes to requester 0 even if requester 3 is also valid.
- With SHARED_ADDER_ARB_FIXED_PRIO_EN: requesters 0 and 2 continuously valid -> requester 0 granted every time; requester 2 granted only after req_valid[0] drops.
